// File: rtl/sdram_mc_arbiter.sv
// Top-level SDRAM bus arbiter: sequences init, refresh (strict priority) and
// NUM_CH round-robin read/write channel engines onto one command/address/DQ bus.
module sdram_mc_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 2,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init_end,
  input  logic [3:0]               init_cmd,
  input  logic [ADDR_W-1:0]        init_addr,
  input  logic                     ref_req,
  output logic                     ref_en,
  input  logic                     ref_end,
  input  logic [3:0]               ref_cmd,
  input  logic [ADDR_W-1:0]        ref_addr,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_end,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [4*NUM_CH-1:0]      ch_cmd,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [BANK_W*NUM_CH-1:0] ch_bank,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [3:0]               sdram_cmd,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [BANK_W-1:0]        sdram_bank,
  output logic [DATA_W-1:0]        sdram_dq_out,
  output logic                     sdram_dq_oe,
  output logic [NUM_CH-1:0]        owner,
  output logic                     timeout_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {INIT, ARBIT, AREF, ACCESS} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr;
  logic [IDX_W-1:0]  own_idx;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [NUM_CH-1:0] pick_oh;
  logic              wr_lat;
  logic [CNT_W-1:0]  wd_cnt;
  logic              wd_fire;

  // Round-robin: first requester scanning upward from the channel after rr.
  always_comb begin
    int j;
    j          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      j = (int'(rr) + i) % NUM_CH;
      if (!pick_valid && ch_req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  assign pick_oh = NUM_CH'(1) << pick_idx;

  generate
    if (TIMEOUT_CYC > 0) begin : g_wd
      assign wd_fire = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      ref_en      <= 1'b0;
      ch_en       <= '0;
      owner       <= '0;
      own_idx     <= '0;
      rr          <= IDX_W'(NUM_CH - 1);
      wr_lat      <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      ref_en <= 1'b0;
      ch_en  <= '0;
      case (state)
        INIT: begin
          wd_cnt <= '0;
          if (init_end) state <= ARBIT;
        end
        ARBIT: begin
          wd_cnt <= '0;
          if (ref_req) begin
            state  <= AREF;
            ref_en <= 1'b1;
          end else if (pick_valid) begin
            state   <= ACCESS;
            ch_en   <= pick_oh;
            owner   <= pick_oh;
            own_idx <= pick_idx;
            rr      <= pick_idx;
            wr_lat  <= ch_wr[pick_idx];
          end
        end
        AREF: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (ref_end) begin
            state <= ARBIT;
          end else if (wd_fire) begin
            state       <= ARBIT;
            timeout_err <= 1'b1;
          end
        end
        ACCESS: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A real completion on the abort cycle still counts as success.
          if (ch_end[own_idx] || wd_fire) begin
            state  <= ARBIT;
            owner  <= '0;
            wr_lat <= 1'b0;
            if (!ch_end[own_idx]) timeout_err <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Bus mux; reset forces NOP immediately rather than waiting for INIT's mux.
  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    if (!rst) begin
      case (state)
        INIT: begin
          sdram_cmd  = init_cmd;
          sdram_addr = init_addr;
        end
        AREF: begin
          sdram_cmd  = ref_cmd;
          sdram_addr = ref_addr;
        end
        ACCESS: begin
          sdram_cmd    = ch_cmd[int'(own_idx)*4 +: 4];
          sdram_addr   = ch_addr[int'(own_idx)*ADDR_W +: ADDR_W];
          sdram_bank   = ch_bank[int'(own_idx)*BANK_W +: BANK_W];
          sdram_dq_out = ch_wdata[int'(own_idx)*DATA_W +: DATA_W];
          sdram_dq_oe  = wr_lat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sdram_mc_arbiter.md
Name: sdram_mc_arbiter

Overview:
- Parametrised successor of the single-port SDRAM top-level arbiter.
- Sequences init, auto-refresh and NUM_CH independent read/write channel engines onto one SDRAM command/address/bank/DQ bus.
- Refresh has strict priority. Channels are served round-robin.
- A per-transaction watchdog forces recovery when an engine never signals completion.

Parameters:
- NUM_CH, 4: number of read/write channel engines (2..8).
- ADDR_W, 12: SDRAM address width.
- BANK_W, 2: bank address width.
- DATA_W, 16: DQ width.
- TIMEOUT_CYC, 1024: max cycles in AREF/ACCESS before forced abort. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- init_end  in  1  init engine done (level).
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}.
- init_addr  in  ADDR_W  init address.
- ref_req  in  1  refresh engine request.
- ref_en  out  1  one-cycle refresh grant.
- ref_end  in  1  refresh done pulse.
- ref_cmd  in  4  refresh command.
- ref_addr  in  ADDR_W  refresh address.
- ch_req  in  NUM_CH  per-channel request.
- ch_en  out  NUM_CH  one-hot one-cycle grant.
- ch_end  in  NUM_CH  per-channel done pulse.
- ch_wr  in  NUM_CH  1 = channel transaction drives DQ.
- ch_cmd  in  4*NUM_CH  per-channel command, channel i at bits [4i+3:4i].
- ch_addr  in  ADDR_W*NUM_CH  per-channel address.
- ch_bank  in  BANK_W*NUM_CH  per-channel bank.
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data.
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}.
- sdram_addr  out  ADDR_W  muxed address.
- sdram_bank  out  BANK_W  muxed bank.
- sdram_dq_out  out  DATA_W  write data to pad.
- sdram_dq_oe  out  1  DQ output enable.
- owner  out  NUM_CH  one-hot current bus owner, 0 if none.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- States: INIT, ARBIT, AREF, ACCESS. Reset forces INIT asynchronously.
- Reset values: ref_en=0, ch_en=0, owner=0, timeout_err=0, rr pointer=NUM_CH-1. Outputs present NOP 4'b0111, addr 0, bank 0, dq_out 0, dq_oe 0.
- INIT:
  - Output mux passes init_cmd/init_addr; bank is 0.
  - Goes to ARBIT on the edge where init_end=1.
- ARBIT:
  - Output is NOP, addr/bank 0.
  - If ref_req=1: go to AREF and pulse ref_en for the following cycle only. Channels are ignored that cycle.
  - Else if any ch_req: pick the first requesting channel scanning upward from rr+1 modulo NUM_CH. Go to ACCESS, pulse ch_en[k] for one cycle, set owner=1<<k, set rr=k, latch ch_wr[k] into wr_lat.
  - Else stay in ARBIT.
- AREF:
  - Output is ref_cmd/ref_addr, bank 0.
  - Go to ARBIT on ref_end=1.
- ACCESS:
  - Output is ch_cmd/ch_addr/ch_bank of the owner. sdram_dq_out = owner's ch_wdata. sdram_dq_oe = wr_lat.
  - Go to ARBIT on ch_end[owner]=1. owner clears on that edge.
  - ch_end from non-owners and ref_end are ignored.
- Output mux is combinational from the registered state/owner. Grant pulses and state change occur on the same edge.
- Grant timing: a request sampled in ARBIT at edge t gives en=1 during cycle t..t+1, with the new state active from t.
- At least one ARBIT cycle separates consecutive transactions. Back-to-back service of one channel costs transaction + 1 cycle.
- Refresh blocks new channel grants but never preempts an active ACCESS. Refresh is taken at the first ARBIT cycle after.
- Watchdog:
  - Counter clears on entry to AREF/ACCESS and increments each cycle there.
  - When the counter reaches TIMEOUT_CYC-1 without the matching end, go to ARBIT next edge, set timeout_err=1 (held until rst), clear owner, and drop dq_oe.
- ch_req deasserting after grant has no effect; completion only via end or watchdog.
- rst mid-transaction: immediate INIT, NOP, dq_oe=0, grants 0, rr reset.

Test Plan:
- Init then idle: init_end rises at cycle 200 -> sdram_cmd follows init_cmd before it, ARBIT from cycle 201, NOP 4'b0111 thereafter, all grants 0.
- Round-robin fairness: NUM_CH=4, all ch_req held high, each channel asserts ch_end 5 cycles after its grant -> grant order 0,1,2,3,0, each grant exactly one cycle wide, 6-cycle spacing.
- Refresh priority: ref_req and ch_req[2] both asserted in ARBIT -> ref_en first. After ref_end, ch_en[2] asserts after exactly one ARBIT cycle. ref_req rising during channel 2's ACCESS does not interrupt it.
- Write DQ drive: channel 1 granted with ch_wr[1]=1, ch_wdata[1]=16'hA5C3 -> sdram_dq_oe=1 and dq_out=16'hA5C3 only while owner=4'b0010. Channel 3 read afterwards -> dq_oe=0.
- Watchdog: TIMEOUT_CYC=16, channel 0 never asserts ch_end -> back to ARBIT 16 cycles after entry, timeout_err=1 stays set, channel 1 granted next.
- Reset mid-ACCESS: assert rst during channel 2 write -> same cycle NOP, dq_oe=0, owner=0. After release, INIT waits for init_end again.
